// File: rtl/bomb_timer_control_if.sv
// Signal bundle between the bomb timer controller and its surroundings
// (prescaler, level time lookup, game logic).
interface bomb_timer_control_if;
  logic       tick_1hz;
  logic       level_start;
  logic       pause;
  logic       defused;
  logic [3:0] load_three;
  logic [3:0] load_two;
  logic [3:0] load_one;
  logic [7:0] game_level;
  logic [3:0] digit_three;
  logic [3:0] digit_two;
  logic [3:0] digit_one;
  logic       running;
  logic       time_up;
  logic       level_done;

  modport master (
    output tick_1hz, level_start, pause, defused,
    output load_three, load_two, load_one,
    input  game_level, digit_three, digit_two, digit_one,
    input  running, time_up, level_done
  );

  modport slave (
    input  tick_1hz, level_start, pause, defused,
    input  load_three, load_two, load_one,
    output game_level, digit_three, digit_two, digit_one,
    output running, time_up, level_done
  );
endinterface

// File: rtl/bomb_timer_control.sv
// Level countdown controller: loads a 3-digit BCD allotment per level, counts it
// down on 1 Hz ticks and reports expiry or a successful defuse.
module bomb_timer_control (
  input  logic                 clk,
  input  logic                 reset,
  bomb_timer_control_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EXPIRED,
    S_CLEARED
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] digits, digits_nxt;
  logic [7:0]  level, level_nxt;
  logic        running, running_nxt;
  logic        time_up, time_up_nxt;
  logic        level_done, level_done_nxt;
  logic        tick_ok;
  logic        at_zero;
  logic        at_one;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Caller guarantees v != 000, so the hundreds borrow never underflows.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign tick_ok = bus.tick_1hz & ~bus.pause;
  assign at_zero = (digits == 12'h000);
  assign at_one  = (digits == 12'h001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      digits     <= 12'h000;
      level      <= 8'h00;
      running    <= 1'b0;
      time_up    <= 1'b0;
      level_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      digits     <= digits_nxt;
      level      <= level_nxt;
      running    <= running_nxt;
      time_up    <= time_up_nxt;
      level_done <= level_done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.level_start) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_RUN;
      S_RUN: begin
        // defused outranks both the zero-entry expiry and the final tick
        if (bus.defused)              state_nxt = S_CLEARED;
        else if (at_zero)             state_nxt = S_EXPIRED;
        else if (tick_ok && at_one)   state_nxt = S_EXPIRED;
      end
      S_EXPIRED: if (bus.level_start) state_nxt = S_LOAD;
      S_CLEARED: if (bus.level_start) state_nxt = S_LOAD;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    digits_nxt     = digits;
    level_nxt      = level;
    time_up_nxt    = 1'b0;
    level_done_nxt = 1'b0;
    case (state)
      S_LOAD: digits_nxt = {clamp_bcd(bus.load_three),
                            clamp_bcd(bus.load_two),
                            clamp_bcd(bus.load_one)};
      S_RUN: begin
        if (bus.defused) begin
          level_done_nxt = 1'b1;
          level_nxt      = sat_inc(level);
        end else if (at_zero) begin
          time_up_nxt = 1'b1;
        end else if (tick_ok) begin
          digits_nxt  = bcd_dec(digits);
          time_up_nxt = at_one;
        end
      end
      S_EXPIRED: if (bus.level_start) level_nxt = 8'h00;
      default: ;
    endcase
    running_nxt = (state_nxt == S_RUN) && !bus.pause;
  end

  assign bus.game_level  = level;
  assign bus.digit_three = digits[11:8];
  assign bus.digit_two   = digits[7:4];
  assign bus.digit_one   = digits[3:0];
  assign bus.running     = running;
  assign bus.time_up     = time_up;
  assign bus.level_done  = level_done;

endmodule

// File: tb/tb_bomb_timer_control.sv
// Scoreboard bench for bomb_timer_control: a seconds-based game model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_bomb_timer_control;

  logic clk;
  logic reset;
  bomb_timer_control_if bus ();

  bomb_timer_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time lookup table indexed by the DUT's current level.
  logic [11:0] lut [0:255];
  assign bus.load_three = lut[bus.game_level][11:8];
  assign bus.load_two   = lut[bus.game_level][7:4];
  assign bus.load_one   = lut[bus.game_level][3:0];

  typedef struct {
    int          cyc;
    logic [22:0] v;
  } exp_t;
  exp_t exp_q[$];

  int cyc_cnt  = 0;
  int n_cmp    = 0;
  int n_fail   = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef enum {PH_IDLE, PH_LOAD, PH_RUN, PH_EXPIRED, PH_CLEARED} ph_t;
  ph_t m_phase = PH_IDLE;
  int  m_secs  = 0;
  int  m_level = 0;
  bit  m_up, m_done, m_run;

  function automatic int lim(input logic [3:0] n);
    return (n > 4'd9) ? 9 : int'(n);
  endfunction

  function automatic logic [22:0] snap_model();
    logic [3:0] h, t, u;
    logic [7:0] lv;
    h  = 4'(m_secs / 100);
    t  = 4'((m_secs / 10) % 10);
    u  = 4'(m_secs % 10);
    lv = 8'(m_level);
    return {lv, h, t, u, m_run, m_up, m_done};
  endfunction

  function automatic logic [22:0] snap_dut();
    return {bus.game_level, bus.digit_three, bus.digit_two, bus.digit_one,
            bus.running, bus.time_up, bus.level_done};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got lvl=%h dig=%h run=%b up=%b done=%b, want lvl=%h dig=%h run=%b up=%b done=%b",
               name, cyc_cnt, act[22:15], act[14:3], act[2], act[1], act[0],
               exp[22:15], exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Advance the game model by one clock edge under the given inputs.
  task automatic model_update(input bit tk, st, pz, df, rs);
    logic [11:0] v;
    if (rs) begin
      m_phase = PH_IDLE; m_secs = 0; m_level = 0;
      m_up = 0; m_done = 0; m_run = 0;
    end else begin
      m_up = 0; m_done = 0;
      case (m_phase)
        PH_IDLE:    if (st) m_phase = PH_LOAD;
        PH_LOAD: begin
          v       = lut[m_level];
          m_secs  = lim(v[11:8]) * 100 + lim(v[7:4]) * 10 + lim(v[3:0]);
          m_phase = PH_RUN;
        end
        PH_RUN: begin
          if (df) begin
            m_done = 1;
            if (m_level < 255) m_level++;
            m_phase = PH_CLEARED;
          end else if (m_secs == 0) begin
            m_up = 1; m_phase = PH_EXPIRED;
          end else if (tk && !pz) begin
            m_secs--;
            if (m_secs == 0) begin m_up = 1; m_phase = PH_EXPIRED; end
          end
        end
        PH_EXPIRED: if (st) begin m_level = 0; m_phase = PH_LOAD; end
        PH_CLEARED: if (st) m_phase = PH_LOAD;
        default: ;
      endcase
      m_run = (m_phase == PH_RUN) && !pz;
    end
  endtask

  // Drive one cycle of inputs, record what must be seen after the next edge.
  task automatic step(input bit tk, st, pz, df, rs);
    exp_t e;
    reset           = rs;
    bus.tick_1hz    = tk;
    bus.level_start = st;
    bus.pause       = pz;
    bus.defused     = df;
    model_update(tk, st, pz, df, rs);
    e.cyc = cyc_cnt + 1;
    e.v   = snap_model();
    exp_q.push_back(e);
    @(posedge clk);
    #6;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic begin_level();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic next_level();
    step(0, 0, 0, 1, 0);
    begin_level();
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      check("outputs", snap_dut(), e.v);
    end
    n_cmp++;
    if (bus.time_up === 1'b1 && bus.level_done === 1'b1) begin
      n_fail++;
      $display("FAIL pulse_exclusive @cyc %0d: time_up=1 level_done=1, want not both", cyc_cnt);
    end
  end

  initial begin
    reset = 1'b1;
    bus.tick_1hz = 0; bus.level_start = 0; bus.pause = 0; bus.defused = 0;
    for (int i = 0; i < 256; i++) lut[i] = 12'($urandom);
    lut[0] = 12'h200;
    lut[3] = 12'h055;
    lut[7] = 12'h030;
    lut[8] = 12'h001;
    lut[255] = 12'h000;
    @(posedge clk);
    #6;

    // Reset, then idle with stray tick/defused.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle_step();
    step(1, 0, 0, 1, 0);

    // Level 0, 200 -> one tick -> 199.
    begin_level();
    idle_step();
    step(1, 0, 0, 0, 0);
    idle_step();

    // Up to level 3 (055), count it all the way out.
    next_level();
    next_level();
    next_level();
    for (int i = 0; i < 55; i++) begin
      step(1, 0, 0, 0, 0);
      idle_step();
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

    // Restart game, climb to level 7 (030), pause over ticks, defuse while paused.
    begin_level();
    for (int i = 0; i < 7; i++) next_level();
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    idle_step();

    // Level 8 (001): defused and final tick together.
    begin_level();
    step(1, 0, 0, 1, 0);
    idle_step();

    // Climb to 255, saturate, then expire on a zero allotment and restart.
    begin_level();
    while (m_level < 255) next_level();
    step(0, 0, 0, 1, 0);
    begin_level();
    idle_step();
    idle_step();
    begin_level();
    idle_step();

    // Reset mid-run at 045, stray inputs in idle, clamped load.
    lut[1] = 12'h045;
    next_level();
    idle_step();
    reset = 1'b1;
    #1;
    check("async_reset", snap_dut(), 23'd0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    lut[0] = 12'h0C3;
    begin_level();
    idle_step();
    step(1, 0, 0, 0, 0);
    idle_step();

    // Randomised play.
    for (int i = 0; i < 256; i++) lut[i] = 12'($urandom);
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 3) == 0, ($urandom % 8) == 0, ($urandom % 5) == 0,
           ($urandom % 12) == 0, ($urandom % 97) == 0);
    end
    idle_step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_timer_control.md
BOMB_TIMER_CONTROL -- requirements
Module: bomb_timer_control

Interface
REQ-001 The block SHALL have exactly one clock and one asynchronous, active-high reset, with the ports below.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse per second from the prescaler
- level_start  in  1  one-cycle pulse: begin or restart a level
- pause  in  1  level signal: freezes countdown while high
- defused  in  1  one-cycle pulse: player solved the current level
- load_three, load_two, load_one  in  4 each  BCD time allotment for current game_level (from time lookup)
- game_level  out  8  current level; drives the time lookup
- digit_three, digit_two, digit_one  out  4 each  remaining time, BCD (hundreds, tens, units)
- running  out  1  high when state RUN and pause low
- time_up  out  1  one-cycle pulse when the countdown reaches 000
- level_done  out  1  one-cycle pulse when a level is cleared

Function
REQ-002 The block SHALL implement states IDLE, LOAD, RUN, EXPIRED and CLEARED, with all outputs registered.
REQ-003 In IDLE, level_start SHALL move the block to LOAD; all other inputs SHALL be ignored.
REQ-004 In LOAD (exactly 1 cycle):
- The digits SHALL capture load_three/two/one.
- Any load nibble above 9 SHALL be clamped to 9.
- The next state SHALL be RUN.
- tick_1hz and defused SHALL be ignored.
REQ-005 load_* SHALL be sampled on the LOAD cycle, so a game_level change made on the edge entering LOAD is reflected in the captured time.
REQ-006 In RUN, a tick_1hz with pause low SHALL decrement the 3-digit value by 1 in BCD.
- Units borrow: 0 becomes 9 and borrows from tens.
- Tens borrow: 0 becomes 9 and borrows from hundreds.
REQ-007 Countdown to zero:
- A tick in RUN when the value is 001 SHALL produce 000, assert time_up for one cycle and enter EXPIRED.
- If RUN is entered with the value 000, the block SHALL enter EXPIRED and pulse time_up on the next cycle without waiting for a tick.
REQ-008 In RUN, tick_1hz SHALL be ignored while pause is high; defused SHALL still be honoured while paused.
REQ-009 A defused pulse in RUN SHALL have the following effect:
- enter CLEARED;
- pulse level_done for one cycle;
- increment game_level by 1, saturating at 8'hFF;
- hold the digits at their current value.
REQ-010 If defused and the final tick (value 001) arrive in the same cycle, defused SHALL win: CLEARED, level_done pulses, time_up stays low, digits remain 001.
REQ-011 level_start SHALL be ignored in LOAD and RUN.
REQ-012 In CLEARED, level_start SHALL enter LOAD with game_level unchanged, i.e. the already-incremented next level.
REQ-013 In EXPIRED:
- The digits SHALL hold 000.
- level_start SHALL clear game_level to 0 on the same edge and enter LOAD (game restart).
REQ-014 running SHALL be 1 only in RUN with pause low; time_up and level_done SHALL never be high in the same cycle.
REQ-015 The digits SHALL never decrement below 000 and SHALL never hold a non-BCD value.

Reset
REQ-016 While reset is high, the following SHALL hold asynchronously:
- state IDLE;
- game_level 0;
- all digits 0;
- running, time_up and level_done 0.
REQ-017 Reset asserted mid-RUN SHALL abort the level immediately, with no time_up or level_done pulse.
REQ-018 After reset deasserts, the block SHALL remain in IDLE until level_start.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Level 0, load=2/0/0, level_start, then 1 tick -> digits 1/9/9 one cycle after the tick; running=1.
- Level 3, load=0/5/5, 55 ticks -> time_up pulses once on the 55th tick; digits 0/0/0; state EXPIRED; further ticks change nothing.
- pause held high over 3 ticks at 0/3/0 -> digits stay 0/3/0, running=0; defused while paused -> level_done pulses and game_level goes 7->8.
- Digits 0/0/1 with defused and tick in the same cycle -> level_done=1, time_up=0, digits 0/0/1, game_level+1.
- game_level=8'hFF, defused -> game_level stays 8'hFF; EXPIRED then level_start -> game_level 0, digits load the level-0 value 2/0/0.
- Reset pulse mid-RUN at 0/4/5 -> all outputs 0 and IDLE; tick and defused ignored until level_start; load nibble 4'hC -> captured as 9.
